qspi_bus_arbiter: RTL and testbench

Shares the single QSPI data/clock bus and SPI flash controller between two read requesters: the RLE video reader (requester 0, high priority) and a secondary reader (requester 1, e.g. palette or audio fetch). Each transaction targets one of three chip selects on the bus: flash, RAM A or RAM B. The block sequences the controller's start, continue and stop pulses and steers the controller's select onto the correct chip select. It enforces a minimum chip-select-high gap between transactions and lets requester 0 preempt requester 1.

---
 rtl/qspi_bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_qspi_bus_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_bus_arbiter.sv
// qspi_bus_arbiter
//   Shares one QSPI bus and flash controller between two read requesters.
//   Requester 0 (video) has priority and can preempt requester 1. The block
//   sequences the controller start/continue/stop pulses, steers the
//   controller's chip select onto flash / RAM A / RAM B, and keeps every
//   chip select high for at least GAP_CYCLES cycles between transactions.
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   rN_req/target/addr        level request, target (3 = invalid), start address
//   rN_next, rN_done          owner pulses: next word / release bus
//   rN_grant, r1_preempt      ownership flags, requester-1 abort pulse
//   ctrl_start/continue/stop  pulses to the flash controller
//   ctrl_addr                 address latched at grant, held for the transaction
//   ctrl_busy, ctrl_select    controller status and active-low select
//   cs_flash/ram_a/ram_b      steered active-low chip selects
module qspi_bus_arbiter #(
  parameter int ADDR_BITS  = 24,
  parameter int GAP_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 r0_req,
  input  logic [1:0]           r0_target,
  input  logic [ADDR_BITS-1:0] r0_addr,
  input  logic                 r0_next,
  input  logic                 r0_done,
  input  logic                 r1_req,
  input  logic [1:0]           r1_target,
  input  logic [ADDR_BITS-1:0] r1_addr,
  input  logic                 r1_next,
  input  logic                 r1_done,
  output logic                 r0_grant,
  output logic                 r1_grant,
  output logic                 r1_preempt,
  output logic                 ctrl_start,
  output logic                 ctrl_continue,
  output logic                 ctrl_stop,
  output logic [ADDR_BITS-1:0] ctrl_addr,
  input  logic                 ctrl_busy,
  input  logic                 ctrl_select,
  output logic                 cs_flash,
  output logic                 cs_ram_a,
  output logic                 cs_ram_b
);

  localparam int CW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_ACTIVE, S_STOP, S_GAP} state_t;

  state_t               state, state_nxt;
  logic                 owner, owner_nxt;
  logic [1:0]           target, target_nxt;
  logic [ADDR_BITS-1:0] addr_nxt;
  logic [CW-1:0]        gap_cnt, gap_nxt;
  logic                 stop_sent;
  logic                 preempt_nxt;

  logic r0_ok, r1_ok, own_next, own_done, cs_on;

  // Target 3 is never granted and must not shadow the other requester.
  assign r0_ok    = r0_req && (r0_target != 2'd3);
  assign r1_ok    = r1_req && (r1_target != 2'd3);
  assign own_next = owner ? r1_next : r0_next;
  assign own_done = owner ? r1_done : r0_done;

  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    target_nxt  = target;
    addr_nxt    = ctrl_addr;
    gap_nxt     = gap_cnt;
    preempt_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (r0_ok) begin
          owner_nxt  = 1'b0;
          target_nxt = r0_target;
          addr_nxt   = r0_addr;
          state_nxt  = S_START;
        end else if (r1_ok) begin
          owner_nxt  = 1'b1;
          target_nxt = r1_target;
          addr_nxt   = r1_addr;
          state_nxt  = S_START;
        end
      end
      S_START: state_nxt = S_ACTIVE;
      S_ACTIVE: begin
        // A requester-1 done that coincides with r0_req is a normal release.
        if (own_done) begin
          state_nxt = S_STOP;
        end else if (owner && r0_ok) begin
          preempt_nxt = 1'b1;
          state_nxt   = S_STOP;
        end
      end
      S_STOP: begin
        if (!ctrl_busy) begin
          gap_nxt   = CW'(GAP_CYCLES);
          state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt <= CW'(1)) state_nxt = S_IDLE;
        else                   gap_nxt   = gap_cnt - CW'(1);
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      target     <= 2'd0;
      ctrl_addr  <= '0;
      gap_cnt    <= '0;
      stop_sent  <= 1'b0;
      r1_preempt <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      target     <= target_nxt;
      ctrl_addr  <= addr_nxt;
      gap_cnt    <= gap_nxt;
      stop_sent  <= (state == S_STOP);
      r1_preempt <= preempt_nxt;
    end
  end

  assign ctrl_start    = (state == S_START);
  // Stop is issued once on STOP entry, however long the controller stays busy.
  assign ctrl_stop     = (state == S_STOP) && !stop_sent;
  assign ctrl_continue = (state == S_ACTIVE) && own_next;
  assign r0_grant      = (state == S_ACTIVE) && !owner;
  assign r1_grant      = (state == S_ACTIVE) && owner;

  assign cs_on    = (state == S_START) || (state == S_ACTIVE) || (state == S_STOP);
  assign cs_flash = (cs_on && target == 2'd0) ? ctrl_select : 1'b1;
  assign cs_ram_a = (cs_on && target == 2'd1) ? ctrl_select : 1'b1;
  assign cs_ram_b = (cs_on && target == 2'd2) ? ctrl_select : 1'b1;

endmodule

// File: tb/tb_qspi_bus_arbiter.sv
// Directed bench for qspi_bus_arbiter (ADDR_BITS=24, GAP_CYCLES=2) followed by
// a short randomized invariant sweep.
module tb_qspi_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_req, r0_next, r0_done, r1_req, r1_next, r1_done;
  logic [1:0]  r0_target, r1_target;
  logic [23:0] r0_addr, r1_addr;
  logic        r0_grant, r1_grant, r1_preempt;
  logic        ctrl_start, ctrl_continue, ctrl_stop;
  logic [23:0] ctrl_addr;
  logic        ctrl_busy, ctrl_select;
  logic        cs_flash, cs_ram_a, cs_ram_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  qspi_bus_arbiter #(.ADDR_BITS(24), .GAP_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_target(r0_target), .r0_addr(r0_addr),
    .r0_next(r0_next), .r0_done(r0_done),
    .r1_req(r1_req), .r1_target(r1_target), .r1_addr(r1_addr),
    .r1_next(r1_next), .r1_done(r1_done),
    .r0_grant(r0_grant), .r1_grant(r1_grant), .r1_preempt(r1_preempt),
    .ctrl_start(ctrl_start), .ctrl_continue(ctrl_continue), .ctrl_stop(ctrl_stop),
    .ctrl_addr(ctrl_addr), .ctrl_busy(ctrl_busy), .ctrl_select(ctrl_select),
    .cs_flash(cs_flash), .cs_ram_a(cs_ram_a), .cs_ram_b(cs_ram_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap_wait();
    // STOP (busy low) -> GAP, GAP, IDLE
    tick(); chk("gap1_start", ctrl_start, 0);
    tick(); chk("gap2_start", ctrl_start, 0);
    tick(); chk("idle_start", ctrl_start, 0);
  endtask

  int last_stop;
  int cyc;
  int lows;

  initial begin
    rst = 1'b1;
    {r0_req, r0_next, r0_done, r1_req, r1_next, r1_done} = '0;
    r0_target = 2'd0; r1_target = 2'd0; r0_addr = '0; r1_addr = '0;
    ctrl_busy = 1'b0; ctrl_select = 1'b0;

    // reset state
    tick(); tick();
    chk("rst_cs", {29'd0, cs_flash, cs_ram_a, cs_ram_b}, 32'h7);
    chk("rst_grants", {r0_grant, r1_grant}, 0);
    chk("rst_pulses", {ctrl_start, ctrl_stop, r1_preempt}, 0);
    chk("rst_addr", ctrl_addr, 0);
    rst = 1'b0;

    // single r0 flash read
    r0_req = 1'b1; r0_target = 2'd0; r0_addr = 24'h000100;
    tick();
    chk("t2_start", ctrl_start, 1);
    chk("t2_addr", ctrl_addr, 32'h000100);
    chk("t2_nogrant", r0_grant, 0);
    chk("t2_cs_low", {cs_flash, cs_ram_a, cs_ram_b}, 3'b011);
    ctrl_select = 1'b1; #1;
    chk("t2_cs_track", cs_flash, 1);
    ctrl_select = 1'b0;
    r0_req = 1'b0;
    tick();
    chk("t2_grant", {r0_grant, r1_grant}, 2'b10);
    chk("t2_start_off", ctrl_start, 0);
    for (int i = 0; i < 3; i++) begin
      r0_next = 1'b1; #1;
      chk("t2_cont_on", ctrl_continue, 1);
      tick();
      r0_next = 1'b0; #1;
      chk("t2_cont_off", ctrl_continue, 0);
      tick();
    end
    r1_next = 1'b1; #1;
    chk("t2_r1next_ign", ctrl_continue, 0);
    r1_next = 1'b0; r1_done = 1'b1;
    tick();
    r1_done = 1'b0;
    chk("t2_r1done_ign", r0_grant, 1);
    r0_done = 1'b1;
    tick();
    r0_done = 1'b0;
    chk("t2_stop", ctrl_stop, 1);
    chk("t2_grant_off", r0_grant, 0);
    chk("t2_stop_cs", cs_flash, 0);
    r0_req = 1'b1; r0_target = 2'd1; r0_addr = 24'h00abcd;
    tick();
    chk("t2_gap_stop", ctrl_stop, 0);
    chk("t2_gap_cs", {cs_flash, cs_ram_a, cs_ram_b}, 3'b111);
    chk("t2_gap_start", ctrl_start, 0);
    tick(); chk("t2_gap2_start", ctrl_start, 0);
    chk("t2_gap2_cs", cs_ram_a, 1);
    tick(); chk("t2_idle_start", ctrl_start, 0);
    tick();
    chk("t2_restart", ctrl_start, 1);
    chk("t2_addr2", ctrl_addr, 32'h00abcd);
    chk("t2_ram_a", {cs_flash, cs_ram_a, cs_ram_b}, 3'b101);
    r0_req = 1'b0;
    tick(); chk("t2_grant2", r0_grant, 1);
    r0_done = 1'b1; tick(); r0_done = 1'b0;
    gap_wait();

    // simultaneous requests: r0 first, then r1 on RAM B
    r0_req = 1'b1; r0_target = 2'd0; r0_addr = 24'h111111;
    r1_req = 1'b1; r1_target = 2'd2; r1_addr = 24'h222222;
    tick();
    chk("t3_start", ctrl_start, 1);
    chk("t3_addr_r0", ctrl_addr, 32'h111111);
    r0_req = 1'b0;
    tick();
    chk("t3_grant_r0", {r0_grant, r1_grant}, 2'b10);
    r0_done = 1'b1; tick(); r0_done = 1'b0;
    chk("t3_no_preempt", r1_preempt, 0);
    gap_wait();
    tick();
    chk("t3_start_r1", ctrl_start, 1);
    chk("t3_addr_r1", ctrl_addr, 32'h222222);
    chk("t3_ram_b", {cs_flash, cs_ram_a, cs_ram_b}, 3'b110);
    r1_req = 1'b0;
    tick();
    chk("t3_grant_r1", {r0_grant, r1_grant}, 2'b01);
    r1_next = 1'b1; #1;
    chk("t3_cont_r1", ctrl_continue, 1);
    r1_next = 1'b0; r0_next = 1'b1; #1;
    chk("t3_r0next_ign", ctrl_continue, 0);
    r0_next = 1'b0;

    // preemption with controller busy 5 cycles
    r0_req = 1'b1; r0_target = 2'd0; r0_addr = 24'h333333;
    tick();
    chk("t4_preempt", r1_preempt, 1);
    chk("t4_stop", ctrl_stop, 1);
    chk("t4_grants_off", {r0_grant, r1_grant}, 0);
    ctrl_busy = 1'b1;
    tick();
    chk("t4_preempt_1cyc", r1_preempt, 0);
    chk("t4_stop_once", ctrl_stop, 0);
    chk("t4_still_stop", cs_ram_b, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_busy_stop", ctrl_stop, 0);
      chk("t4_busy_cs", cs_ram_b, 0);
    end
    ctrl_busy = 1'b0;
    gap_wait();
    tick();
    chk("t4_r0_start", ctrl_start, 1);
    chk("t4_r0_addr", ctrl_addr, 32'h333333);
    chk("t4_flash", {cs_flash, cs_ram_a, cs_ram_b}, 3'b011);
    r0_req = 1'b0;
    r1_req = 1'b1; r1_target = 2'd1; r1_addr = 24'h444444;
    tick(); chk("t4_grant_r0", r0_grant, 1);
    tick();
    chk("t4_r1_no_preempt", r1_preempt, 0);
    chk("t4_r0_keeps", r0_grant, 1);
    r0_done = 1'b1; tick(); r0_done = 1'b0;
    gap_wait();
    tick(); chk("t5_r1_addr", ctrl_addr, 32'h444444);
    r1_req = 1'b0;
    tick(); chk("t5_r1_grant", r1_grant, 1);

    // r1_done coincident with r0_req: normal release
    r0_req = 1'b1; r0_target = 2'd2; r0_addr = 24'h555555; r1_done = 1'b1;
    tick();
    r1_done = 1'b0;
    chk("t5_no_preempt", r1_preempt, 0);
    chk("t5_stop", ctrl_stop, 1);
    gap_wait();
    tick();
    chk("t5_r0_addr", ctrl_addr, 32'h555555);
    chk("t5_ram_b", cs_ram_b, 0);
    r0_req = 1'b0;
    tick(); chk("t5_r0_grant", r0_grant, 1);
    r0_done = 1'b1; tick(); r0_done = 1'b0;
    gap_wait();

    // r0 invalid target does not block r1 and never preempts
    r0_req = 1'b1; r0_target = 2'd3; r0_addr = 24'h666666;
    r1_req = 1'b1; r1_target = 2'd1; r1_addr = 24'h777777;
    tick();
    chk("t6_start", ctrl_start, 1);
    chk("t6_addr", ctrl_addr, 32'h777777);
    tick();
    chk("t6_grant", {r0_grant, r1_grant}, 2'b01);
    tick();
    chk("t6_no_preempt", r1_preempt, 0);
    chk("t6_keep", r1_grant, 1);

    // reset mid-ACTIVE
    r0_req = 1'b0; r1_req = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t7_no_stop", ctrl_stop, 0);
    end
    rst = 1'b0;
    chk("t7_cs", {cs_flash, cs_ram_a, cs_ram_b}, 3'b111);
    chk("t7_grants", {r0_grant, r1_grant}, 0);
    chk("t7_pulses", {ctrl_start, ctrl_stop, r1_preempt}, 0);
    chk("t7_addr", ctrl_addr, 0);
    tick();
    chk("t7_idle", ctrl_start, 0);

    // randomized invariant sweep
    last_stop = -1000;
    for (cyc = 0; cyc < 3000; cyc++) begin
      r0_req      = ($urandom_range(0, 7) == 0);
      r1_req      = ($urandom_range(0, 2) == 0);
      r0_target   = 2'($urandom_range(0, 3));
      r1_target   = 2'($urandom_range(0, 3));
      r0_addr     = 24'($urandom);
      r1_addr     = 24'($urandom);
      r0_next     = ($urandom_range(0, 1) == 0);
      r1_next     = ($urandom_range(0, 1) == 0);
      r0_done     = ($urandom_range(0, 7) == 0);
      r1_done     = ($urandom_range(0, 7) == 0);
      ctrl_busy   = ($urandom_range(0, 2) == 0);
      ctrl_select = ($urandom_range(0, 3) != 0);
      tick();
      lows = 0;
      if (!cs_flash) lows++;
      if (!cs_ram_a) lows++;
      if (!cs_ram_b) lows++;
      chk("soak_one_grant", r0_grant & r1_grant, 0);
      chk("soak_one_cs", (lows > 1) ? 1 : 0, 0);
      chk("soak_start_stop", ctrl_start & ctrl_stop, 0);
      if (ctrl_stop) last_stop = cyc;
      if (ctrl_start) chk("soak_gap", (cyc - last_stop < 4) ? 1 : 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
